keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SCAN_DIV, 50000, clk50 cycles each row stays driven (minimum 4).
REQ-002 DEBOUNCE_N, 4, consecutive matching row samples needed to accept a press or a release (minimum 2).
REQ-003 FIFO_DEPTH, 4, key-code buffer entries (power of two).
REQ-004 clk50  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 Columna  in  4  keypad columns, active-low, asynchronous to clk50.
REQ-007 Fila  out  4  keypad row drive, active-low, one-cold.
REQ-008 key_code  out  4  FIFO head, {row[1:0], col[1:0]}.
REQ-009 key_valid  out  1  FIFO non-empty.
REQ-010 key_ready  in  1  consumer accepts head when key_valid=1.
REQ-011 key_held  out  1  an accepted key is still pressed.
REQ-012 overflow  out  1  sticky; a press was dropped because the FIFO was full.
REQ-013 ovf_clr  in  1  clears overflow.

Function
REQ-014 Columna SHALL pass through a 2-flop synchronizer before any use.
REQ-015 A slot counter SHALL count 0..SCAN_DIV-1 and then wrap; the synchronized columns SHALL be sampled only when the count equals SCAN_DIV-1.
REQ-016 States SHALL be SCAN, DEBOUNCE, HELD and RELEASE.
REQ-017 SCAN: at each sample with all columns high, the row SHALL advance 0->1->2->3->0, and Fila SHALL change on the cycle after the sample.
REQ-018 SCAN: at a sample with any column low, the row SHALL freeze, the lowest-index low column SHALL be latched as the candidate, debounce count SHALL be set to 1, and the state SHALL go to DEBOUNCE.
REQ-019 DEBOUNCE: the block SHALL stay on the frozen row.
REQ-020 DEBOUNCE: a sample equal to the candidate SHALL increment the count; on reaching DEBOUNCE_N the block SHALL push the code and go to HELD.
REQ-021 DEBOUNCE: any other sample SHALL return the state to SCAN, and the row SHALL advance.
REQ-022 HELD: key_held SHALL be 1; a sample with all columns high SHALL go to RELEASE with count 1.
REQ-023 RELEASE: each all-high sample SHALL increment the count, and reaching DEBOUNCE_N SHALL go to SCAN with the row advanced.
REQ-024 RELEASE: any low sample SHALL return the state to HELD and push nothing, so a key produces exactly one code per press.
REQ-025 Pop SHALL occur when key_valid and key_ready; key_code SHALL show the next entry on the following cycle.
REQ-026 The push SHALL be the cycle after the accepting sample; key_valid SHALL rise 1 cycle after the push when the FIFO was empty.
REQ-027 Push while full with no pop SHALL drop the code, set overflow, and leave the FIFO unchanged.
REQ-028 Push and pop in the same cycle when full SHALL both succeed, with no overflow.
REQ-029 Push and pop in the same cycle when empty SHALL not occur: key_valid=0 blocks the pop.
REQ-030 ovf_clr SHALL clear overflow; a simultaneous overflow set SHALL win.
REQ-031 Keys held on a non-driven row SHALL be invisible until their row is scanned; multiple keys on one row SHALL be resolved by lowest column.

Reset
REQ-032 When rst=1 at a clock edge: state=SCAN, row=0, Fila=4'b1110, slot and debounce counters=0, FIFO empty, key_valid=0, key_code=0, key_held=0, overflow=0, synchronizer flops=4'b1111.
REQ-033 Reset mid-press SHALL discard the in-progress debounce; a key still held after reset SHALL be re-detected and pushed once.

Structure
REQ-034 Package keypad_pkg SHALL hold: the state enum, ROWS=4, COLS=4, CODE_W=4, and the code-packing function.
REQ-035 The FIFO SHALL be sub-module keypad_fifo, with push/pop/full/empty and a synchronous active-high reset.
REQ-036 The scan FSM, counters and synchronizer SHALL reside in keypad_scan_ctrl.

Verification (SCAN_DIV=4, DEBOUNCE_N=3)
REQ-037 Reset, then no key: Fila SHALL cycle 1110,1101,1011,0111 with a 4-cycle period per row; key_valid SHALL stay 0.
REQ-038 Row 2, col 1 held stable, key_ready=1 → exactly one key_code=4'b1001 pulse on key_valid, with key_held=1 until release.
REQ-039 Row 1, col 3 low for 2 samples then high (bounce) → no push, state SHALL return to SCAN, Fila SHALL advance to 1011.
REQ-040 key_ready=0, 5 distinct presses → 4 codes buffered in order, overflow=1 after the 5th, and ovf_clr SHALL clear it.
REQ-041 FIFO full and a 5th press accepted in the same cycle as a pop → no overflow, occupancy SHALL remain 4.
REQ-042 rst asserted during DEBOUNCE on row 3 → outputs SHALL equal their reset values; the key still held SHALL be pushed once after re-scan.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// matrix geometry and the {row, col} key-code packing.
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  function automatic logic [CODE_W-1:0] pack_code(input logic [1:0] row,
                                                  input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small key-code FIFO; a push into a full buffer is accepted only when a pop
// frees a slot in the same cycle. The head reads as zero while empty.
module keypad_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CODE_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one row low at a time, debounces presses
// and releases on slot samples, and queues one key code per press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic [3:0] Columna,
  output logic [3:0] Fila,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int             SW        = $clog2(SCAN_DIV);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam int             DW        = $clog2(DEBOUNCE_N + 1);
  localparam logic [DW-1:0]  DEB_LAST  = DW'(DEBOUNCE_N);

  logic [3:0]        col_s1_q, col_s2_q;
  logic [SW-1:0]     slot_q;
  state_e            state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        cand_q, cand_d;
  logic [DW-1:0]     deb_q, deb_d, deb_inc;
  logic              push_q, push_d;
  logic [CODE_W-1:0] push_code_q;
  logic              ovf_q;
  logic              sample, any_low, pop, fifo_full, fifo_empty;
  logic [1:0]        low_col;

  function automatic logic [1:0] lowest_low(input logic [COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign sample  = (slot_q == SLOT_LAST);
  assign any_low = ~&col_s2_q;
  assign low_col = lowest_low(col_s2_q);
  assign deb_inc = deb_q + DW'(1);

  // Input synchronizer and sample-slot timebase
  always_ff @(posedge clk50) begin
    if (rst) begin
      col_s1_q <= 4'b1111;
      col_s2_q <= 4'b1111;
      slot_q   <= '0;
    end else begin
      col_s1_q <= Columna;
      col_s2_q <= col_s1_q;
      slot_q   <= sample ? '0 : slot_q + SW'(1);
    end
  end

  // Scan FSM state register
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q <= SCAN;
      row_q   <= '0;
      cand_q  <= '0;
      deb_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      push_q  <= push_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cand_d  = cand_q;
    deb_d   = deb_q;
    push_d  = 1'b0;
    if (sample) begin
      unique case (state_q)
        SCAN: begin
          if (any_low) begin
            cand_d  = low_col;
            deb_d   = DW'(1);
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (any_low && (low_col == cand_q)) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_LAST) begin
              push_d  = 1'b1;
              state_d = HELD;
            end
          end else begin
            deb_d   = '0;
            state_d = SCAN;
            row_d   = row_q + 2'd1;
          end
        end
        HELD: begin
          if (!any_low) begin
            deb_d   = DW'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (!any_low) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_LAST) begin
              deb_d   = '0;
              state_d = SCAN;
              row_d   = row_q + 2'd1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Release debouncing still counts as holding the accepted key.
  always_comb begin
    Fila        = 4'b1111;
    Fila[row_q] = 1'b0;
    key_held    = (state_q == HELD) || (state_q == RELEASE);
  end

  // Code is captured on the accepting sample and pushed the next cycle.
  always_ff @(posedge clk50) begin
    if (push_d) push_code_q <= pack_code(row_q, cand_q);
  end

  assign pop       = key_valid && key_ready;
  assign key_valid = ~fifo_empty;

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CODE_W)
  ) u_fifo (
    .clk_i   (clk50),
    .rst_i   (rst),
    .push_i  (push_q),
    .pop_i   (pop),
    .din_i   (push_code_q),
    .dout_o  (key_code),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A dropped push outranks a simultaneous clear.
  always_ff @(posedge clk50) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (push_q && fifo_full && !pop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives the columns from
// the row drive, and a code scoreboard checks every pop against the presses.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 3;
  localparam int FIFO_DEPTH = 4;

  logic        clk50;
  logic        rst;
  logic [3:0]  Columna;
  logic [3:0]  Fila;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overflow;
  logic        ovf_clr;

  logic [15:0] pressed;
  logic [3:0]  col_model;
  logic [3:0]  exp_q[$];
  bit          exp_ovf;
  bit          rnd_ready;
  int          n_checks;
  int          n_err;
  int          pop_cnt;
  int          base;

  keypad_scan_ctrl #(
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE_N (DEBOUNCE_N),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk50     (clk50),
    .rst       (rst),
    .Columna   (Columna),
    .Fila      (Fila),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  // A pressed key pulls its column low only while its row is driven low.
  always_comb begin
    col_model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!Fila[r] && pressed[r*4+c]) col_model[c] = 1'b0;
      end
    end
  end
  assign Columna = col_model;

  function automatic logic [3:0] row_pat(input int r);
    logic [3:0] p;
    p    = 4'hF;
    p[r] = 1'b0;
    return p;
  endfunction

  function automatic logic [3:0] code_of(input int r, input int c);
    return 4'(r * 4 + c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; any pop about to happen is scored against the expected queue.
  task automatic tick();
    logic [3:0] e;
    if (key_valid && key_ready) begin
      pop_cnt++;
      e = 4'bxxxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("pop_code", 32'(key_code), 32'(e));
    end
    @(posedge clk50);
    @(negedge clk50);
    if (rnd_ready) key_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_fila(input logic [3:0] pat, input bit need_edge, input string tag);
    int         n;
    logic [3:0] prev;
    bit         hit;
    n   = 0;
    hit = !need_edge && (Fila == pat);
    while (!hit && n < 200) begin
      prev = Fila;
      tick();
      n++;
      hit = (Fila == pat) && (!need_edge || prev != pat);
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic press_key(input int r, input int c, input int hold, input int rel);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(code_of(r, c));
    else exp_ovf = 1'b1;
    pressed[r*4+c] = 1'b1;
    repeat (hold) tick();
    pressed[r*4+c] = 1'b0;
    repeat (rel) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fila"},  32'(Fila),      32'(4'b1110));
    chk({tag, "_valid"}, 32'(key_valid), 32'd0);
    chk({tag, "_code"},  32'(key_code),  32'd0);
    chk({tag, "_held"},  32'(key_held),  32'd0);
    chk({tag, "_ovf"},   32'(overflow),  32'd0);
  endtask

  initial begin
    int first_k;
    n_checks  = 0;
    n_err     = 0;
    pop_cnt   = 0;
    exp_ovf   = 1'b0;
    rnd_ready = 1'b0;
    rst       = 1'b1;
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
    pressed   = '0;
    @(negedge clk50);
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Idle scan: each row driven for SCAN_DIV cycles, nothing queued.
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("idle_fila", 32'(Fila), 32'(row_pat((k / SCAN_DIV) % 4)));
      chk("idle_valid", 32'(key_valid), 32'd0);
    end

    // Row 2 col 1 held from reset: one code, then key_held until released.
    rst       = 1'b1;
    key_ready = 1'b1;
    pressed[2*4+1] = 1'b1;
    exp_q.push_back(code_of(2, 1));
    tick();
    tick();
    rst     = 1'b0;
    base    = pop_cnt;
    first_k = SCAN_DIV * (2 + DEBOUNCE_N) + 1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == first_k - 1) chk("single_valid_early", 32'(key_valid), 32'd0);
      if (k == first_k) begin
        chk("single_valid_rise", 32'(key_valid), 32'd1);
        chk("single_code", 32'(key_code), 32'(code_of(2, 1)));
      end
      if (k == first_k + 1) chk("single_valid_fall", 32'(key_valid), 32'd0);
      if (k == 30) chk("single_held", 32'(key_held), 32'd1);
      if (k == 40) pressed[2*4+1] = 1'b0;
      if (k == 60) chk("single_released", 32'(key_held), 32'd0);
    end
    chk("single_pops", 32'(pop_cnt - base), 32'd1);

    // Bounce on row 1 col 3: two matching samples, then high.
    wait_fila(row_pat(0), 1'b0, "bounce_wait_row0");
    pressed[1*4+3] = 1'b1;
    wait_fila(row_pat(1), 1'b1, "bounce_wait_row1");
    repeat (8) tick();
    pressed[1*4+3] = 1'b0;
    repeat (3) tick();
    chk("bounce_frozen", 32'(Fila), 32'(row_pat(1)));
    tick();
    chk("bounce_advance", 32'(Fila), 32'(4'b1011));
    base = pop_cnt;
    repeat (40) tick();
    chk("bounce_nopush", 32'(pop_cnt - base), 32'd0);
    chk("bounce_valid", 32'(key_valid), 32'd0);

    // Two keys on row 0: lowest column wins.
    base = pop_cnt;
    exp_q.push_back(code_of(0, 1));
    pressed[0*4+1] = 1'b1;
    pressed[0*4+2] = 1'b1;
    repeat (48) tick();
    pressed = '0;
    repeat (24) tick();
    chk("multi_pops", 32'(pop_cnt - base), 32'd1);

    // Five presses with no consumer: four buffered, fifth dropped.
    key_ready = 1'b0;
    tick();
    press_key(0, 0, 48, 24);
    press_key(1, 2, 48, 24);
    press_key(2, 3, 48, 24);
    press_key(3, 1, 48, 24);
    chk("fill_ovf_before", 32'(overflow), 32'd0);
    chk("fill_valid", 32'(key_valid), 32'd1);
    press_key(0, 3, 48, 24);
    chk("fill_ovf_after", 32'(overflow), 32'(exp_ovf));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'(exp_ovf));
    base      = pop_cnt;
    key_ready = 1'b1;
    repeat (8) tick();
    chk("drain_pops", 32'(pop_cnt - base), 32'd4);
    chk("drain_empty", 32'(key_valid), 32'd0);

    // Full buffer: fifth push lands in the same cycle as a pop.
    key_ready = 1'b0;
    tick();
    press_key(1, 0, 48, 24);
    press_key(2, 2, 48, 24);
    press_key(3, 3, 48, 24);
    press_key(0, 1, 48, 24);
    chk("full_valid", 32'(key_valid), 32'd1);
    wait_fila(row_pat(1), 1'b0, "same_wait_row1");
    pressed[2*4+0] = 1'b1;
    wait_fila(row_pat(2), 1'b1, "same_wait_row2");
    repeat (SCAN_DIV * DEBOUNCE_N) tick();
    key_ready = 1'b1;
    exp_q.push_back(code_of(2, 0));
    tick();
    key_ready = 1'b0;
    chk("same_cycle_ovf", 32'(overflow), 32'd0);
    repeat (20) tick();
    pressed[2*4+0] = 1'b0;
    repeat (24) tick();
    chk("same_cycle_ovf_late", 32'(overflow), 32'd0);
    base      = pop_cnt;
    key_ready = 1'b1;
    repeat (8) tick();
    chk("same_cycle_occupancy", 32'(pop_cnt - base), 32'd4);
    chk("same_cycle_empty", 32'(key_valid), 32'd0);

    // Reset while debouncing row 3; key still held is pushed once later.
    wait_fila(row_pat(2), 1'b0, "rst_wait_row2");
    pressed[3*4+0] = 1'b1;
    wait_fila(row_pat(3), 1'b1, "rst_wait_row3");
    repeat (SCAN_DIV + 2) tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.push_back(code_of(3, 0));
    base = pop_cnt;
    repeat (60) tick();
    pressed[3*4+0] = 1'b0;
    repeat (40) tick();
    chk("midrst_pops", 32'(pop_cnt - base), 32'd1);
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);

    // Random single-key presses with a randomly stalling consumer.
    rnd_ready = 1'b1;
    base      = pop_cnt;
    for (int i = 0; i < 12; i++) begin
      press_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                48 + int'($urandom_range(0, 16)), 24 + int'($urandom_range(0, 16)));
    end
    rnd_ready = 1'b0;
    key_ready = 1'b1;
    repeat (10) tick();
    chk("rand_pops", 32'(pop_cnt - base), 32'd12);
    chk("rand_queue", 32'(exp_q.size()), 32'd0);
    chk("rand_ovf", 32'(overflow), 32'(exp_ovf));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
